// File: rtl/mac_accumulator.sv
// mac_accumulator: sums a run of unsigned multiplier products into a
// guard-extended, saturating accumulator behind valid/ready handshakes.
`default_nettype none

module mac_accumulator #(
  parameter int parallelism = 8,
  parameter int ACC_GUARD   = 8,
  parameter int LEN_WIDTH   = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [LEN_WIDTH-1:0]                 length,
  input  logic [2*parallelism-1:0]             product,
  input  logic                                 product_valid,
  output logic                                 product_ready,
  output logic [2*parallelism+ACC_GUARD-1:0]   acc_out,
  output logic                                 acc_valid,
  input  logic                                 acc_ready,
  output logic                                 overflow,
  output logic                                 busy
);

  localparam int AW = 2*parallelism + ACC_GUARD;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          acc_q, acc_d;
  logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic [AW:0]            sum_w;

  // One extra bit catches the carry out of the accumulator's MSB.
  assign sum_w = {1'b0, acc_q} + {{(ACC_GUARD+1){1'b0}}, product};

  assign product_ready = (state_q == S_ACC);
  assign acc_valid     = (state_q == S_DONE);
  assign busy          = (state_q != S_IDLE);
  assign acc_out       = acc_q;
  assign overflow      = ovf_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (length != '0) begin
            cnt_d   = length;
            state_d = S_ACC;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ACC: begin
        if (product_valid) begin
          cnt_d = cnt_q - 1'b1;
          // Once saturated the sum is pinned at all-ones until the next start.
          if (sum_w[AW] || ovf_q) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum_w[AW-1:0];
          end
          if (cnt_q == LEN_WIDTH'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (acc_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed stimulus shared by a default instance and a
// zero-guard instance, both compared every cycle against a behavioural model.
`default_nettype none

module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  length = '0;
  logic [15:0] product = '0;
  logic        product_valid = 1'b0;
  logic        acc_ready = 1'b0;

  logic        pr_m, av_m, ov_m, bz_m;
  logic [23:0] ao_m;
  logic        pr_s, av_s, ov_s, bz_s;
  logic [15:0] ao_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_accumulator #(.parallelism(8), .ACC_GUARD(8), .LEN_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .length(length),
    .product(product), .product_valid(product_valid), .product_ready(pr_m),
    .acc_out(ao_m), .acc_valid(av_m), .acc_ready(acc_ready),
    .overflow(ov_m), .busy(bz_m)
  );

  mac_accumulator #(.parallelism(8), .ACC_GUARD(0), .LEN_WIDTH(8)) u_sat (
    .clk(clk), .rst(rst), .start(start), .length(length),
    .product(product), .product_valid(product_valid), .product_ready(pr_s),
    .acc_out(ao_s), .acc_valid(av_s), .acc_ready(acc_ready),
    .overflow(ov_s), .busy(bz_s)
  );

  // Model: phase 0 = waiting, 1 = collecting beats, 2 = result offered.
  int     m_phase;
  int     m_rem;
  longint m_sum [2];
  bit     m_ovf [2];
  longint m_max [2];
  initial begin
    m_max[0] = (64'd1 << 24) - 1;
    m_max[1] = (64'd1 << 16) - 1;
  end

  function automatic longint sat_add(input longint a, input longint b, input longint mx);
    return (a + b > mx) ? mx : a + b;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_rem   <= 0;
      for (int i = 0; i < 2; i++) begin
        m_sum[i] <= 0;
        m_ovf[i] <= 1'b0;
      end
    end else begin
      case (m_phase)
        0: if (start) begin
          for (int i = 0; i < 2; i++) begin
            m_sum[i] <= 0;
            m_ovf[i] <= 1'b0;
          end
          m_rem   <= int'(length);
          m_phase <= (length == 0) ? 2 : 1;
        end
        1: if (product_valid) begin
          for (int i = 0; i < 2; i++) begin
            m_sum[i] <= sat_add(m_sum[i], longint'(product), m_max[i]);
            m_ovf[i] <= m_ovf[i] || (m_sum[i] + longint'(product) > m_max[i]);
          end
          m_rem <= m_rem - 1;
          if (m_rem == 1) m_phase <= 2;
        end
        default: if (acc_ready) m_phase <= 0;
      endcase
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy",          longint'(bz_m), longint'(m_phase != 0));
    chk("product_ready", longint'(pr_m), longint'(m_phase == 1));
    chk("acc_valid",     longint'(av_m), longint'(m_phase == 2));
    chk("acc_out",       longint'(ao_m), m_sum[0]);
    chk("overflow",      longint'(ov_m), longint'(m_ovf[0]));
    chk("sat.busy",          longint'(bz_s), longint'(m_phase != 0));
    chk("sat.product_ready", longint'(pr_s), longint'(m_phase == 1));
    chk("sat.acc_valid",     longint'(av_s), longint'(m_phase == 2));
    chk("sat.acc_out",       longint'(ao_s), m_sum[1]);
    chk("sat.overflow",      longint'(ov_s), longint'(m_ovf[1]));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    chk("reset acc_out", longint'(ao_m), 0);
    chk("reset busy", longint'(bz_m), 0);

    // Basic run: 4 x 0x0121 back-to-back.
    tick();
    start = 1'b1; length = 8'd4; product = 16'h0121; product_valid = 1'b1; acc_ready = 1'b1;
    tick(); start = 1'b0;
    chk("basic ready cycle1", longint'(pr_m), 1);
    repeat (3) tick();
    chk("basic not valid c4", longint'(av_m), 0);
    tick(); product_valid = 1'b0;
    chk("basic valid c5", longint'(av_m), 1);
    chk("basic acc_out", longint'(ao_m), 24'h000484);
    chk("basic overflow", longint'(ov_m), 0);
    tick();
    chk("basic idle after", longint'(bz_m), 0);
    chk("basic acc_out kept", longint'(ao_m), 24'h000484);

    // Bubbles and backpressure.
    acc_ready = 1'b0; start = 1'b1; length = 8'd3;
    tick(); start = 1'b0; product = 16'h0001; product_valid = 1'b1;
    tick(); product_valid = 1'b0;
    tick();
    tick(); product = 16'h00FF; product_valid = 1'b1;
    tick(); product_valid = 1'b0;
    tick();
    tick(); product = 16'hFFFF; product_valid = 1'b1;
    tick(); product_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp valid held", longint'(av_m), 1);
      chk("bp acc_out held", longint'(ao_m), 24'h0100FF);
      if (i < 4) tick();
    end
    acc_ready = 1'b1;
    tick();
    chk("bp valid dropped", longint'(av_m), 0);
    chk("bp sat overflow kept", longint'(ov_s), 1);

    // Zero length.
    acc_ready = 1'b0; start = 1'b1; length = 8'd0;
    tick(); start = 1'b0;
    chk("zero valid", longint'(av_m), 1);
    chk("zero acc_out", longint'(ao_m), 0);
    chk("zero ready low", longint'(pr_m), 0);
    acc_ready = 1'b1;
    tick();
    tick();

    // Saturation on the zero-guard instance.
    start = 1'b1; length = 8'd3; product = 16'hFFFF; product_valid = 1'b1;
    tick(); start = 1'b0;
    tick(); product = 16'h0001;
    tick(); product = 16'h0005;
    tick(); product_valid = 1'b0;
    chk("sat acc_out", longint'(ao_s), 16'hFFFF);
    chk("sat overflow", longint'(ov_s), 1);
    chk("wide acc_out", longint'(ao_m), 24'h010005);
    chk("wide overflow", longint'(ov_m), 0);
    tick();
    start = 1'b1; length = 8'd1; product = 16'h0002; product_valid = 1'b1;
    tick(); start = 1'b0;
    tick(); product_valid = 1'b0;
    chk("sat rerun acc_out", longint'(ao_s), 16'h0002);
    chk("sat rerun overflow", longint'(ov_s), 0);
    tick();

    // Ignored inputs: product_valid in IDLE, start in ACC and DONE.
    product = 16'h0055; product_valid = 1'b1;
    tick(); tick();
    chk("idle pv ignored", longint'(ao_m), 24'h000002);
    product_valid = 1'b0; acc_ready = 1'b0; start = 1'b1; length = 8'd2;
    tick(); start = 1'b0;
    tick(); start = 1'b1; length = 8'd7; product = 16'h0010; product_valid = 1'b1;
    tick(); start = 1'b0;
    tick(); product_valid = 1'b0; start = 1'b1; length = 8'd3;
    tick(); start = 1'b0;
    chk("ign done valid", longint'(av_m), 1);
    chk("ign acc_out", longint'(ao_m), 24'h000020);
    acc_ready = 1'b1;
    tick();
    chk("ign back idle", longint'(bz_m), 0);

    // Reset mid-run after two of four beats.
    start = 1'b1; length = 8'd4; product = 16'h0300; product_valid = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    chk("mid partial", longint'(ao_m), 24'h000600);
    #2 rst = 1'b1;
    #1;
    chk("rst acc_out", longint'(ao_m), 0);
    chk("rst busy", longint'(bz_m), 0);
    chk("rst ready", longint'(pr_m), 0);
    chk("rst valid", longint'(av_m), 0);
    chk("rst overflow", longint'(ov_m), 0);
    chk("rst sat acc_out", longint'(ao_s), 0);
    product_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    start = 1'b1; length = 8'd1; product = 16'h0121; product_valid = 1'b1;
    tick(); start = 1'b0;
    tick(); product_valid = 1'b0;
    chk("post rst valid", longint'(av_m), 1);
    chk("post rst acc_out", longint'(ao_m), 24'h000121);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
